// File: rtl/rx_byte_word_packer.sv
// rx_byte_word_packer
// Packs the decoded PSDU byte stream from the dot11 receiver into 64-bit little-endian words
// for the host DMA path. After the FCS verdict one status word is appended. That word carries
// fcs_ok, the packet serial number, the received byte count and the header length.
//
// Ports
//   clock                    system clock
//   reset                    synchronous, active-high
//   enable                   low: all state held, no strobes issued
//   pkt_header_valid_strobe  start of packet; latches pkt_len and restarts packing
//   pkt_len[15:0]            PSDU length in bytes, sampled with the header strobe
//   byte_in[7:0]             decoded byte
//   byte_in_strobe           byte_in valid (single-cycle)
//   fcs_out_strobe           end of packet; fcs_ok valid this cycle
//   fcs_ok                   1 = CRC32 passed
//   word_out[63:0]           packed data word or status word (held between strobes)
//   word_out_strobe          word_out valid (single-cycle)
//   word_last                qualifies word_out_strobe: this is the status word
//   pkt_sn[SN_WIDTH-1:0]     serial number of the next packet to complete
module rx_byte_word_packer #(
  parameter int unsigned SN_WIDTH = 8,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                pkt_header_valid_strobe,
  input  logic [15:0]         pkt_len,
  input  logic [7:0]          byte_in,
  input  logic                byte_in_strobe,
  input  logic                fcs_out_strobe,
  input  logic                fcs_ok,
  output logic [63:0]         word_out,
  output logic                word_out_strobe,
  output logic                word_last,
  output logic [SN_WIDTH-1:0] pkt_sn
);

  // StFlush:  the final data word (padded partial, or the word completed by the byte that
  //           arrived with the FCS strobe) is on the bus; the status word follows next edge.
  // StStatus: the status word is on the bus; the serial number advances on exit.
  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StFlush,
    StStatus
  } state_t;

  state_t              r_state;
  logic [63:0]         r_shift;
  logic [2:0]          r_lane;
  logic [15:0]         r_byte_cnt;
  logic [15:0]         r_pkt_len;
  logic                r_fcs_ok;
  logic [63:0]         r_word_out;
  logic                r_word_strobe;
  logic                r_word_last;
  logic [SN_WIDTH-1:0] r_pkt_sn;

  logic                w_accept;
  logic                w_word_full;
  logic [63:0]         w_shift_nxt;
  logic [63:0]         w_pad_word;
  logic [2:0]          w_lane_nxt;
  logic [15:0]         w_cnt_nxt;
  logic [7:0]          w_sn_byte;

  // Bytes beyond the advertised length are dropped and never counted.
  assign w_accept    = (r_state == StCollect) && byte_in_strobe && (r_byte_cnt < r_pkt_len);
  assign w_word_full = w_accept && (r_lane == 3'd7);
  assign w_lane_nxt  = r_lane + 3'(w_accept);
  assign w_cnt_nxt   = r_byte_cnt + 16'(w_accept);

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt[8*r_lane +: 8] = byte_in;
    end
  end

  // Partial word as it would look after this cycle's byte; unfilled lanes carry PAD_BYTE.
  always_comb begin
    w_pad_word = '0;
    for (int i = 0; i < 8; i++) begin
      w_pad_word[8*i +: 8] = (i < int'(w_lane_nxt)) ? w_shift_nxt[8*i +: 8] : PAD_BYTE;
    end
  end

  // The status word always carries an 8-bit serial field.
  if (SN_WIDTH >= 8) begin : g_sn_trunc
    assign w_sn_byte = r_pkt_sn[7:0];
  end else begin : g_sn_ext
    assign w_sn_byte = {{(8 - SN_WIDTH){1'b0}}, r_pkt_sn};
  end

  function automatic logic [63:0] status_word(input logic        ok,
                                              input logic [7:0]  sn,
                                              input logic [15:0] cnt,
                                              input logic [15:0] len);
    return {ok, 7'd0, sn, 16'd0, cnt, len};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StIdle;
      r_shift       <= '0;
      r_lane        <= '0;
      r_byte_cnt    <= '0;
      r_pkt_len     <= '0;
      r_fcs_ok      <= 1'b0;
      r_word_out    <= '0;
      r_word_strobe <= 1'b0;
      r_word_last   <= 1'b0;
      r_pkt_sn      <= '0;
    end else begin
      r_word_strobe <= 1'b0;
      r_word_last   <= 1'b0;
      if (enable) begin
        if (pkt_header_valid_strobe) begin
          // Restart; any packet in progress is abandoned without a status word.
          r_pkt_len  <= pkt_len;
          r_shift    <= '0;
          r_lane     <= '0;
          r_byte_cnt <= '0;
          r_state    <= StCollect;
          // A status word already on the bus still counts as a completed packet.
          if (r_state == StStatus) begin
            r_pkt_sn <= r_pkt_sn + SN_WIDTH'(1);
          end
        end else begin
          unique case (r_state)
            StIdle: begin
            end
            StCollect: begin
              r_shift    <= w_shift_nxt;
              r_lane     <= w_lane_nxt;
              r_byte_cnt <= w_cnt_nxt;
              if (w_word_full) begin
                r_word_out    <= w_shift_nxt;
                r_word_strobe <= 1'b1;
                r_shift       <= '0;
              end
              if (fcs_out_strobe) begin
                r_fcs_ok <= fcs_ok;
                if (w_word_full) begin
                  // Completed word goes out now; status on the following edge.
                  r_state <= StFlush;
                end else if (w_lane_nxt != 3'd0) begin
                  r_word_out    <= w_pad_word;
                  r_word_strobe <= 1'b1;
                  r_state       <= StFlush;
                end else begin
                  r_word_out    <= status_word(fcs_ok, w_sn_byte, w_cnt_nxt, r_pkt_len);
                  r_word_strobe <= 1'b1;
                  r_word_last   <= 1'b1;
                  r_state       <= StStatus;
                end
              end
            end
            StFlush: begin
              r_word_out    <= status_word(r_fcs_ok, w_sn_byte, r_byte_cnt, r_pkt_len);
              r_word_strobe <= 1'b1;
              r_word_last   <= 1'b1;
              r_state       <= StStatus;
            end
            StStatus: begin
              r_pkt_sn <= r_pkt_sn + SN_WIDTH'(1);
              r_state  <= StIdle;
            end
            default: r_state <= StIdle;
          endcase
        end
      end
    end
  end

  assign word_out        = r_word_out;
  assign word_out_strobe = r_word_strobe;
  assign word_last       = r_word_last;
  assign pkt_sn          = r_pkt_sn;

endmodule

// File: tb/tb_rx_byte_word_packer.sv
// Testbench for rx_byte_word_packer. Randomized packets are run through the DUT. A monitor
// collects every output word. Each scenario compares the collected words with a reference
// list built from the packet contents by plain chunking arithmetic.
module tb_rx_byte_word_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        hdr = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_in_strobe = 1'b0;
  logic        fcs_out_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic [63:0] word_out;
  logic        word_out_strobe;
  logic        word_last;
  logic [7:0]  pkt_sn;

  rx_byte_word_packer #(.SN_WIDTH(8), .PAD_BYTE(8'h00)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .pkt_header_valid_strobe(hdr),
    .pkt_len                (pkt_len),
    .byte_in                (byte_in),
    .byte_in_strobe         (byte_in_strobe),
    .fcs_out_strobe         (fcs_out_strobe),
    .fcs_ok                 (fcs_ok),
    .word_out               (word_out),
    .word_out_strobe        (word_out_strobe),
    .word_last              (word_last),
    .pkt_sn                 (pkt_sn)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        last;
    logic [63:0] w;
    int          cyc;
  } ent_t;

  ent_t       got_q[$];
  ent_t       exp_q[$];
  logic [7:0] pkt_bytes[$];
  int         vectors = 0;
  int         errors = 0;
  int         sn_model = 0;

  always @(negedge clock) begin
    if (word_out_strobe === 1'b1) got_q.push_back(ent_t'{word_last, word_out, cyc});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Reference: accepted bytes chunked into 8-byte little-endian words, last one zero-padded,
  // then the status word.
  task automatic build_exp(input int len, input bit fcs);
    int n;
    int acc;
    logic [63:0] w;
    n = pkt_bytes.size();
    acc = (n < len) ? n : len;
    exp_q.delete();
    for (int b = 0; b < acc; b += 8) begin
      w = '0;
      for (int k = 0; k < 8 && b + k < acc; k++) w[8*k +: 8] = pkt_bytes[b + k];
      exp_q.push_back(ent_t'{1'b0, w, 0});
    end
    exp_q.push_back(ent_t'{1'b1, {fcs, 7'd0, 8'(sn_model), 16'd0, 16'(acc), 16'(len)}, 0});
  endtask

  // Header, the bytes in pkt_bytes with realistic spacing, then the FCS strobe. With junk set,
  // some gaps carry a byte strobe while enable is low, which must be lost.
  task automatic drive_pkt(input int len, input bit fcs, input bit fcs_with_last,
                           input bit junk, output int fcs_cyc);
    int n;
    n = pkt_bytes.size();
    fcs_cyc = 0;
    hdr = 1'b1;
    pkt_len = 16'(len);
    tick();
    hdr = 1'b0;
    idle(3);
    for (int i = 0; i < n; i++) begin
      byte_in = pkt_bytes[i];
      byte_in_strobe = 1'b1;
      if (fcs_with_last && i == n - 1) begin
        fcs_out_strobe = 1'b1;
        fcs_ok = fcs;
        fcs_cyc = cyc;
      end
      tick();
      byte_in_strobe = 1'b0;
      fcs_out_strobe = 1'b0;
      idle(2);
      if (junk && $urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        byte_in = 8'($urandom);
        byte_in_strobe = 1'b1;
        tick();
        byte_in_strobe = 1'b0;
        idle($urandom_range(0, 3));
        enable = 1'b1;
      end
      idle($urandom_range(5, 7));
    end
    if (!fcs_with_last) begin
      fcs_out_strobe = 1'b1;
      fcs_ok = fcs;
      fcs_cyc = cyc;
      tick();
      fcs_out_strobe = 1'b0;
    end
    idle(6);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    vectors++;
    if (word_out !== 64'd0 || word_out_strobe !== 1'b0 || word_last !== 1'b0 ||
        pkt_sn !== 8'd0) begin
      errors++;
      $display("FAIL reset: word=%h stb=%b last=%b sn=%0d, want all zero",
               word_out, word_out_strobe, word_last, pkt_sn);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int fc;
    pkt_bytes.delete();
    for (int k = 0; k < 16; k++) pkt_bytes.push_back(8'(k));
    got_q.delete();
    drive_pkt(16, 1'b1, 1'b0, 1'b0, fc);
    vectors++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL basic_count: got %0d words, want 3", got_q.size());
    end else begin
      vectors += 4;
      if (got_q[0].w !== 64'h0706050403020100 || got_q[0].last !== 1'b0) begin
        errors++;
        $display("FAIL basic_w0: got %h/%b, want 0706050403020100/0", got_q[0].w, got_q[0].last);
      end
      if (got_q[1].w !== 64'h0F0E0D0C0B0A0908 || got_q[1].last !== 1'b0) begin
        errors++;
        $display("FAIL basic_w1: got %h/%b, want 0f0e0d0c0b0a0908/0", got_q[1].w, got_q[1].last);
      end
      if (got_q[2].w !== 64'h8000_0000_0010_0010 || got_q[2].last !== 1'b1) begin
        errors++;
        $display("FAIL basic_status: got %h/%b, want 8000000000100010/1",
                 got_q[2].w, got_q[2].last);
      end
      if (got_q[2].cyc != fc + 1) begin
        errors++;
        $display("FAIL basic_status_latency: got cycle %0d, want %0d", got_q[2].cyc, fc + 1);
      end
    end
    sn_model = (sn_model + 1) % 256;
    vectors++;
    if (pkt_sn !== 8'(sn_model)) begin
      errors++;
      $display("FAIL basic_sn: got %0d, want %0d", pkt_sn, sn_model);
    end
  endtask

  task automatic test_len100();
    int fc;
    pkt_bytes.delete();
    for (int k = 0; k < 100; k++) pkt_bytes.push_back(8'(k));
    build_exp(100, 1'b1);
    got_q.delete();
    drive_pkt(100, 1'b1, 1'b0, 1'b0, fc);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL len100_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last) begin
          errors++;
          $display("FAIL len100_w%0d: got %h/%b, want %h/%b", i, got_q[i].w, got_q[i].last,
                   exp_q[i].w, exp_q[i].last);
        end
      end
      vectors += 3;
      if (got_q[12].w !== 64'h0000_0000_6362_6160) begin
        errors++;
        $display("FAIL len100_flush: got %h, want 0000000063626160", got_q[12].w);
      end
      if (got_q[12].cyc != fc + 1) begin
        errors++;
        $display("FAIL len100_flush_latency: got cycle %0d, want %0d", got_q[12].cyc, fc + 1);
      end
      if (got_q[13].cyc != fc + 2) begin
        errors++;
        $display("FAIL len100_status_latency: got cycle %0d, want %0d", got_q[13].cyc, fc + 2);
      end
    end
    sn_model = (sn_model + 1) % 256;
  endtask

  task automatic test_abort();
    int fc;
    int sn_before;
    sn_before = sn_model;
    got_q.delete();
    hdr = 1'b1;
    pkt_len = 16'd20;
    tick();
    hdr = 1'b0;
    idle(2);
    for (int k = 0; k < 5; k++) begin
      byte_in = 8'($urandom);
      byte_in_strobe = 1'b1;
      tick();
      byte_in_strobe = 1'b0;
      idle(8);
    end
    pkt_bytes.delete();
    for (int k = 0; k < 8; k++) pkt_bytes.push_back(8'($urandom));
    build_exp(8, 1'b1);
    drive_pkt(8, 1'b1, 1'b0, 1'b0, fc);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last) begin
          errors++;
          $display("FAIL abort_w%0d: got %h/%b, want %h/%b", i, got_q[i].w, got_q[i].last,
                   exp_q[i].w, exp_q[i].last);
        end
      end
    end
    sn_model = (sn_before + 1) % 256;
    vectors++;
    if (pkt_sn !== 8'(sn_model)) begin
      errors++;
      $display("FAIL abort_sn: got %0d, want %0d", pkt_sn, sn_model);
    end
  endtask

  task automatic test_fcs_with_last();
    int fc;
    pkt_bytes.delete();
    for (int k = 0; k < 8; k++) pkt_bytes.push_back(8'($urandom));
    build_exp(8, 1'b1);
    got_q.delete();
    drive_pkt(8, 1'b1, 1'b1, 1'b0, fc);
    vectors++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL fcs_last_count: got %0d words, want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last ||
            got_q[i].cyc != fc + 1 + i) begin
          errors++;
          $display("FAIL fcs_last_w%0d: got %h/%b @%0d, want %h/%b @%0d", i, got_q[i].w,
                   got_q[i].last, got_q[i].cyc, exp_q[i].w, exp_q[i].last, fc + 1 + i);
        end
      end
    end
    sn_model = (sn_model + 1) % 256;
  endtask

  task automatic test_overlen();
    int fc;
    pkt_bytes.delete();
    for (int k = 0; k < 6; k++) pkt_bytes.push_back(8'($urandom));
    build_exp(4, 1'b1);
    got_q.delete();
    drive_pkt(4, 1'b1, 1'b0, 1'b0, fc);
    vectors++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL overlen_count: got %0d words, want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last) begin
          errors++;
          $display("FAIL overlen_w%0d: got %h/%b, want %h/%b", i, got_q[i].w, got_q[i].last,
                   exp_q[i].w, exp_q[i].last);
        end
      end
      vectors++;
      if (got_q[1].w[31:16] !== 16'd4) begin
        errors++;
        $display("FAIL overlen_bytecnt: got %0d, want 4", got_q[1].w[31:16]);
      end
    end
    sn_model = (sn_model + 1) % 256;
  endtask

  task automatic test_sn_wrap();
    int fc;
    int start_sn;
    start_sn = sn_model;
    pkt_bytes.delete();
    pkt_bytes.push_back(8'hAB);
    for (int p = 0; p < 256; p++) begin
      build_exp(1, 1'b0);
      got_q.delete();
      drive_pkt(1, 1'b0, 1'b0, 1'b0, fc);
      vectors++;
      if (got_q.size() != 2 || got_q[0].w !== 64'h0000_0000_0000_00AB ||
          got_q[0].last !== 1'b0 || got_q[1].w !== exp_q[1].w || got_q[1].last !== 1'b1) begin
        errors++;
        $display("FAIL wrap_pkt%0d: %0d words, status got %h, want %h", p, got_q.size(),
                 (got_q.size() > 1) ? got_q[1].w : 64'd0, exp_q[1].w);
      end
      sn_model = (sn_model + 1) % 256;
      vectors++;
      if (pkt_sn !== 8'(sn_model)) begin
        errors++;
        $display("FAIL wrap_sn%0d: got %0d, want %0d", p, pkt_sn, sn_model);
      end
    end
    vectors++;
    if (pkt_sn !== 8'(start_sn)) begin
      errors++;
      $display("FAIL wrap_full_cycle: got %0d, want %0d", pkt_sn, start_sn);
    end
  endtask

  task automatic test_reset_mid();
    int fc;
    got_q.delete();
    hdr = 1'b1;
    pkt_len = 16'd30;
    tick();
    hdr = 1'b0;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      byte_in = 8'($urandom);
      byte_in_strobe = 1'b1;
      tick();
      byte_in_strobe = 1'b0;
      idle(8);
    end
    reset = 1'b1;
    idle(2);
    vectors++;
    if (word_out !== 64'd0 || word_out_strobe !== 1'b0 || word_last !== 1'b0 ||
        pkt_sn !== 8'd0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: word=%h stb=%b last=%b sn=%0d words=%0d, want zeros",
               word_out, word_out_strobe, word_last, pkt_sn, got_q.size());
    end
    reset = 1'b0;
    sn_model = 0;
    idle(2);
    pkt_bytes.delete();
    for (int k = 0; k < 11; k++) pkt_bytes.push_back(8'($urandom));
    build_exp(11, 1'b1);
    drive_pkt(11, 1'b1, 1'b0, 1'b0, fc);
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d words, want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last) begin
          errors++;
          $display("FAIL reset_mid_w%0d: got %h/%b, want %h/%b", i, got_q[i].w,
                   got_q[i].last, exp_q[i].w, exp_q[i].last);
        end
      end
    end
    sn_model = (sn_model + 1) % 256;
  endtask

  task automatic test_random();
    int fc;
    int len;
    int n;
    bit fcs;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 40);
      n = $urandom_range((len > 3) ? len - 3 : 0, len + 3);
      fcs = 1'($urandom_range(0, 1));
      pkt_bytes.delete();
      for (int k = 0; k < n; k++) pkt_bytes.push_back(8'($urandom));
      build_exp(len, fcs);
      got_q.delete();
      drive_pkt(len, fcs, 1'b0, 1'b1, fc);
      vectors++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d words, want %0d (len %0d, bytes %0d)", p,
                 got_q.size(), exp_q.size(), len, n);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          vectors++;
          if (got_q[i].w !== exp_q[i].w || got_q[i].last !== exp_q[i].last) begin
            errors++;
            $display("FAIL rand%0d_w%0d: got %h/%b, want %h/%b", p, i, got_q[i].w,
                     got_q[i].last, exp_q[i].w, exp_q[i].last);
          end
        end
      end
      sn_model = (sn_model + 1) % 256;
      vectors++;
      if (pkt_sn !== 8'(sn_model)) begin
        errors++;
        $display("FAIL rand%0d_sn: got %0d, want %0d", p, pkt_sn, sn_model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len100();
    test_abort();
    test_fcs_with_last();
    test_overlen();
    test_sn_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
